// File: rtl/sink_checker_if.sv
// Valid/ready bus between the incrementing-data source and its sink.
// Handshake: a word transfers on a rising clk edge where valid && ready are both 1.
// Once valid is raised it must stay high with data unchanged until that edge; ready
// may rise or fall freely and must not depend combinationally on valid.
interface valid_ready #(
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport Master (output valid, output data, input ready);
  modport Slave  (input valid, input data, output ready);
endinterface

// File: rtl/sink_checker.sv
// Throttling sink for the incrementing-data source: inserts a programmable ready-low
// gap after each transfer, checks the +1 data sequence and the upstream hold protocol.
module sink_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int DELAY_BITS = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DELAY_BITS-1:0] delay,
  valid_ready.Slave             vrBus,
  output logic [CNT_WIDTH-1:0]  rx_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [DATA_WIDTH-1:0] last_data,
  output logic                  mismatch,
  output logic                  error,
  output logic                  proto_err,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_DELAY = 3'b010;
  localparam logic [2:0] S_READY = 3'b100;

  logic [2:0]            r_state;
  logic [2:0]            w_next_state;
  logic [DELAY_BITS-1:0] r_dcnt;
  logic [DELAY_BITS-1:0] r_dly_q;
  logic                  w_ready;
  logic                  w_hs;
  logic                  w_delay_done;

  logic [DATA_WIDTH-1:0] r_expected;
  logic [DATA_WIDTH-1:0] r_last_data;
  logic [CNT_WIDTH-1:0]  r_rx_count;
  logic [CNT_WIDTH-1:0]  r_err_count;
  logic                  r_mismatch;
  logic                  r_error;
  logic                  r_proto_err;
  logic                  r_stalled;
  logic [DATA_WIDTH-1:0] r_stall_data;

  assign w_hs         = vrBus.valid && w_ready;
  assign w_delay_done = (r_dcnt + 1'b1) == r_dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = (delay == '0) ? S_READY : S_DELAY;
      S_DELAY: w_next_state = w_delay_done ? S_READY : S_DELAY;
      S_READY: if (w_hs) w_next_state = (delay == '0) ? S_READY : S_DELAY;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Ready comes purely from the registered state, so it never loops through valid.
  always_comb begin
    w_ready   = (r_state == S_READY);
    dbg_state = r_state;
  end

  // delay is latched only when a gap starts; later changes wait for the next transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dcnt  <= '0;
      r_dly_q <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_dcnt  <= '0;
          r_dly_q <= delay;
        end
        S_DELAY: r_dcnt <= r_dcnt + 1'b1;
        S_READY: if (w_hs) begin
          r_dcnt  <= '0;
          r_dly_q <= delay;
        end
        default: r_dcnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_expected  <= DATA_WIDTH'(1);
      r_last_data <= '0;
      r_rx_count  <= '0;
      r_err_count <= '0;
      r_mismatch  <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      if (w_hs) begin
        r_last_data <= vrBus.data;
        r_expected  <= vrBus.data + 1'b1;
        if (r_rx_count != '1) r_rx_count <= r_rx_count + 1'b1;
        if (vrBus.data != r_expected) begin
          if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
          r_mismatch <= 1'b1;
          r_error    <= 1'b1;
        end
      end
    end
  end

  // A stalled word (valid && !ready) must be re-presented unchanged in the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stalled    <= 1'b0;
      r_stall_data <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_stalled    <= vrBus.valid && !w_ready;
      r_stall_data <= vrBus.data;
      if (r_stalled && (!vrBus.valid || vrBus.data != r_stall_data)) r_proto_err <= 1'b1;
    end
  end

  assign vrBus.ready = w_ready;
  assign rx_count    = r_rx_count;
  assign err_count   = r_err_count;
  assign last_data   = r_last_data;
  assign mismatch    = r_mismatch;
  assign error       = r_error;
  assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_sink_checker.sv
// Directed and randomized stimulus for sink_checker, checked every cycle against a
// transfer-level reference model of gap timing, sequence checking and hold protocol.
module tb_sink_checker;
  localparam int DW = 8;
  localparam int DB = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DB-1:0] delay;
  logic [CW-1:0] rx_count, err_count;
  logic [DW-1:0] last_data;
  logic          mismatch, error, proto_err;
  logic [2:0]    dbg_state;

  valid_ready #(.DATA_WIDTH(DW)) vr_if ();

  sink_checker #(.DATA_WIDTH(DW), .DELAY_BITS(DB), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .delay     (delay),
    .vrBus     (vr_if),
    .rx_count  (rx_count),
    .err_count (err_count),
    .last_data (last_data),
    .mismatch  (mismatch),
    .error     (error),
    .proto_err (proto_err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit            m_idle;
  int            m_low;
  bit            m_ready;
  logic [CW-1:0] m_rx, m_err;
  logic [DW-1:0] m_exp, m_last, m_stall_data;
  bit            m_mis, m_error, m_proto, m_stall;
  logic [DW-1:0] exp_q[$];

  task automatic model_reset();
    m_idle = 1; m_low = 0; m_ready = 0;
    m_rx = '0; m_err = '0; m_exp = 8'd1; m_last = '0;
    m_mis = 0; m_error = 0; m_proto = 0; m_stall = 0; m_stall_data = '0;
    exp_q.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ready", 32'(vr_if.ready), 32'(m_ready));
    chk("rx_count", 32'(rx_count), 32'(m_rx));
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("last_data", 32'(last_data), 32'(m_last));
    chk("mismatch", 32'(mismatch), 32'(m_mis));
    chk("error", 32'(error), 32'(m_error));
    chk("proto_err", 32'(proto_err), 32'(m_proto));
  endtask

  // Advance one clock: update the model from the inputs presented this cycle, then check.
  task automatic tick();
    bit hs;
    hs = vr_if.valid && m_ready;
    if (m_stall && (!vr_if.valid || vr_if.data !== m_stall_data)) m_proto = 1;
    m_stall      = vr_if.valid && !m_ready;
    m_stall_data = vr_if.data;
    m_mis = 0;
    if (hs) begin
      m_last = vr_if.data;
      if (m_rx != '1) m_rx = m_rx + 1'b1;
      if (vr_if.data != m_exp) begin
        if (m_err != '1) m_err = m_err + 1'b1;
        m_mis = 1; m_error = 1;
      end
      m_exp = vr_if.data + 8'd1;
    end
    if (m_idle) begin m_idle = 0; m_low = int'(delay); end
    else if (m_low > 0) m_low--;
    else if (hs) m_low = int'(delay);
    m_ready = !m_idle && (m_low == 0);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit took;
    vr_if.valid = 1'b1;
    vr_if.data  = d;
    for (int i = 0; i < 40; i++) begin
      took = m_ready;
      tick();
      if (took) return;
    end
    n_checks++; n_errors++;
    $error("FAIL send_timeout observed=no_handshake expected=handshake data=%0h", d);
  endtask

  task automatic idle(input int n);
    vr_if.valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vr_if.valid = 1'b0;
    vr_if.data  = '0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; delay = 3'd2; vr_if.valid = 1'b0; vr_if.data = '0;
    do_reset();

    // delay=2, sequence 1,2,3 with two ready-low cycles after each handshake
    idle(1);
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(DW'(i));
      send(DW'(i));
    end
    idle(3);
    chk("seq_last", 32'(last_data), 32'(exp_q[$]));

    // delay=0, back-to-back transfers with valid held high
    do_reset();
    delay = 3'd0;
    idle(1);
    for (int i = 1; i <= 5; i++) send(DW'(i));
    idle(2);
    chk("b2b_rx", 32'(rx_count), 32'd5);

    // Sequence break 1,2,7,8 then resync; also 254,255,0 wrap
    do_reset();
    delay = 3'd1;
    idle(1);
    send(8'd1); send(8'd2); send(8'd7); send(8'd8);
    send(8'd254); send(8'd255); send(8'd0);
    idle(2);
    chk("wrap_last", 32'(last_data), 32'd0);

    // Protocol violation: word stalled by a long gap, then changed before handshake
    do_reset();
    delay = 3'd7;
    idle(1);
    send(8'd1);
    send(8'd2);
    vr_if.valid = 1'b1; vr_if.data = 8'd3;
    tick();
    vr_if.data = 8'd4;
    tick();
    tick();
    vr_if.valid = 1'b0;
    idle(8);

    // Asynchronous reset in the middle of a delay gap
    do_reset();
    delay = 3'd3;
    idle(1);
    for (int i = 1; i <= 6; i++) send(DW'(i));
    idle(1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    reset = 1'b0;
    delay = 3'd0;
    tick();
    send(8'd1);
    idle(1);

    // Randomized traffic with varying gaps, injected errors and counter saturation
    do_reset();
    idle(1);
    for (int i = 0; i < 200; i++) begin
      logic [DW-1:0] d;
      delay = DB'($urandom_range(0, 4));
      d = ($urandom_range(0, 7) == 0) ? DW'($urandom) : m_exp;
      send(d);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
